// File: rtl/ftb_setassoc_pkg.sv
// Shared frontend definitions for the fetch target buffer.
// Holds the branch type, target status, entry info layout and the walker FSM states.
package ftb_setassoc_pkg;
  localparam int FTB_TARGET_W   = 20;
  localparam int FTB_FALLTHRU_W = 4;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JAL  = 2'd2,
    BR_JALR = 2'd3
  } BranchType;

  // Relation of the target's upper PC field to the fetch PC's upper field.
  typedef enum logic [1:0] {
    TAR_FIT = 2'd0,
    TAR_OVF = 2'd1,
    TAR_UDF = 2'd2
  } tarStat_t;

  typedef struct packed {
    BranchType                 brType;
    tarStat_t                  tarStat;
    logic                      carry;
    logic [FTB_FALLTHRU_W-1:0] fallthruAddr;
    logic [FTB_TARGET_W-1:0]   targetAddr;
    logic [1:0]                counter;
  } ftbInfo_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ftb_state_e;

  function automatic logic [1:0] sat_counter(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
    return (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
  endfunction
endpackage

// File: rtl/ftb_setassoc_addr_calc.sv
// Rebuilds full fall-through and target PCs from a fetch PC and the stored offsets.
// Purely combinational; upper-field arithmetic wraps within its own width.
module ftb_addr_calc
  import ftb_setassoc_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int TARGET_W   = FTB_TARGET_W,
  parameter int FALLTHRU_W = FTB_FALLTHRU_W
) (
  input  logic [XLEN-1:0] pc,
  input  ftbInfo_t        info,
  output logic [XLEN-1:0] fallthru,
  output logic [XLEN-1:0] target
);
  localparam int FT_HI_W = XLEN - FALLTHRU_W - 1;
  localparam int TG_HI_W = XLEN - TARGET_W - 1;

  logic [FT_HI_W-1:0] ft_hi;
  logic [TG_HI_W-1:0] tg_hi;
  logic [TG_HI_W-1:0] pc_tg_hi;
  logic               unused_bits;

  assign pc_tg_hi = pc[XLEN-1:TARGET_W+1];

  always_comb begin
    ft_hi = pc[XLEN-1:FALLTHRU_W+1] + FT_HI_W'(info.carry);
    // The unused fourth encoding falls through to FIT.
    case (info.tarStat)
      TAR_OVF: tg_hi = pc_tg_hi + TG_HI_W'(1);
      TAR_UDF: tg_hi = pc_tg_hi - TG_HI_W'(1);
      default: tg_hi = pc_tg_hi;
    endcase
  end

  assign fallthru    = {ft_hi, FALLTHRU_W'(info.fallthruAddr), 1'b0};
  assign target      = {tg_hi, TARGET_W'(info.targetAddr), 1'b0};
  assign unused_bits = ^{pc[FALLTHRU_W:0], info.brType, info.counter};
endmodule

// File: rtl/ftb_setassoc.sv
// Set-associative fetch target buffer: one registered lookup and one training update per cycle,
// with a set-per-cycle invalidation walk after reset or flush.
module ftb_setassoc
  import ftb_setassoc_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int SETS       = 256,
  parameter int WAYS       = 4,
  parameter int TAG_W      = 16,
  parameter int TARGET_W   = FTB_TARGET_W,
  parameter int FALLTHRU_W = FTB_FALLTHRU_W,
  localparam int IDX_W     = $clog2(SETS),
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  output logic             init_done,
  input  logic             lkp_vld,
  input  logic [XLEN-1:0]  lkp_pc,
  output logic             lkp_rdy,
  output logic             resp_vld,
  output logic             resp_hit,
  output logic [WAY_W-1:0] resp_way,
  output ftbInfo_t         resp_info,
  output logic [XLEN-1:0]  resp_fallthru,
  output logic [XLEN-1:0]  resp_target,
  input  logic             upd_vld,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  ftbInfo_t         upd_info
);
  // Handshake: a lookup transfers in a cycle where lkp_vld && lkp_rdy; updates have no ready and
  // win the array over lookups; resp_vld pulses for one cycle in the cycle after each transfer.

  logic [WAYS-1:0]  vld_q  [SETS];
  logic [TAG_W-1:0] tag_q  [SETS][WAYS];
  ftbInfo_t         info_q [SETS][WAYS];
  logic [WAY_W-1:0] rr_q   [SETS];

  ftb_state_e       state, state_nx;
  logic [IDX_W-1:0] walk_q, walk_nx;

  logic             lkp_fire, upd_fire;
  logic [IDX_W-1:0] lkp_idx, upd_idx;
  logic [TAG_W-1:0] lkp_tag, upd_tag;
  logic             lkp_hit, upd_hit, has_inv, evict;
  logic [WAY_W-1:0] lkp_way, upd_hit_way, inv_way, upd_sel, rr_nx;
  ftbInfo_t         upd_new;
  logic             resp_vld_q;
  logic [XLEN-1:0]  resp_pc;
  logic             unused_upd;

  assign init_done = (state == ST_RUN);
  assign lkp_rdy   = init_done & ~upd_vld & ~flush;
  assign lkp_fire  = lkp_vld & lkp_rdy;
  assign upd_fire  = upd_vld & init_done & ~flush;

  assign lkp_idx = lkp_pc[IDX_W:1];
  assign lkp_tag = lkp_pc[IDX_W+TAG_W:IDX_W+1];
  assign upd_idx = upd_pc[IDX_W:1];
  assign upd_tag = upd_pc[IDX_W+TAG_W:IDX_W+1];

  assign unused_upd = ^{upd_pc[XLEN-1:IDX_W+TAG_W+1], upd_pc[0], upd_info.counter};

  always_comb begin
    state_nx = state;
    walk_nx  = walk_q;
    case (state)
      ST_INIT: begin
        walk_nx = walk_q + IDX_W'(1);
        if (walk_q == IDX_W'(SETS - 1)) state_nx = ST_RUN;
      end
      default: state_nx = state;
    endcase
    if (flush) begin
      state_nx = ST_INIT;
      walk_nx  = '0;
    end
  end

  // Descending scans leave the lowest matching / lowest invalid way selected.
  always_comb begin
    lkp_hit = 1'b0;
    lkp_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (vld_q[lkp_idx][w] && tag_q[lkp_idx][w] == lkp_tag) begin
        lkp_hit = 1'b1;
        lkp_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    upd_hit     = 1'b0;
    upd_hit_way = '0;
    has_inv     = 1'b0;
    inv_way     = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (vld_q[upd_idx][w] && tag_q[upd_idx][w] == upd_tag) begin
        upd_hit     = 1'b1;
        upd_hit_way = WAY_W'(w);
      end
      if (!vld_q[upd_idx][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    upd_sel = upd_hit ? upd_hit_way : (has_inv ? inv_way : rr_q[upd_idx]);
    evict   = ~upd_hit & ~has_inv;
    rr_nx   = (rr_q[upd_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[upd_idx] + WAY_W'(1);
    upd_new = upd_info;
    if (upd_hit) upd_new.counter = sat_counter(info_q[upd_idx][upd_hit_way].counter, upd_taken);
    else         upd_new.counter = upd_taken ? 2'd2 : 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_INIT;
      walk_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        vld_q[s] <= '0;
        rr_q[s]  <= '0;
      end
    end else begin
      state  <= state_nx;
      walk_q <= walk_nx;
      if (state == ST_INIT) begin
        vld_q[walk_q] <= '0;
        rr_q[walk_q]  <= '0;
      end else if (upd_fire) begin
        vld_q[upd_idx][upd_sel] <= 1'b1;
        if (evict) rr_q[upd_idx] <= rr_nx;
      end
    end
  end

  // Tags and info are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    if (upd_fire) begin
      tag_q[upd_idx][upd_sel]  <= upd_tag;
      info_q[upd_idx][upd_sel] <= upd_new;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_vld_q <= 1'b0;
      resp_hit   <= 1'b0;
      resp_way   <= '0;
      resp_info  <= '0;
      resp_pc    <= '0;
    end else begin
      resp_vld_q <= lkp_fire;
      if (lkp_fire) begin
        resp_hit  <= lkp_hit;
        resp_way  <= lkp_hit ? lkp_way : '0;
        resp_info <= lkp_hit ? info_q[lkp_idx][lkp_way] : '0;
        resp_pc   <= lkp_pc;
      end
    end
  end

  assign resp_vld = resp_vld_q & ~flush;

  ftb_addr_calc #(
    .XLEN       (XLEN),
    .TARGET_W   (TARGET_W),
    .FALLTHRU_W (FALLTHRU_W)
  ) u_addr_calc (
    .pc       (resp_pc),
    .info     (resp_info),
    .fallthru (resp_fallthru),
    .target   (resp_target)
  );
endmodule

// File: doc/ftb_setassoc.md
# ftb_setassoc

Parametrised set-associative Fetch Target Buffer for the frontend branch predictor. It holds `ftbEntry_t`-style entries across `SETS`×`WAYS` storage, answers one lookup per cycle with a registered response carrying reconstructed fall-through and target PCs, and accepts one training update per cycle with saturating counter maintenance and victim replacement. Sits between the BPU next-PC stage (lookup) and the FTQ commit path (update). It supersedes the fixed-geometry, combinational-only address helpers with a stateful, configurable array plus an invalidation walker.

## Interface
Parameters:
- `XLEN`, 64, PC width.
- `SETS`, 256, number of sets; power of two, ≥2.
- `WAYS`, 4, associativity; power of two, ≥1.
- `TAG_W`, 16, stored tag width.
- `TARGET_W`, 20, stored target offset width (halfword units).
- `FALLTHRU_W`, 4, stored fall-through offset width (halfword units).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  invalidate all entries; restarts the init walk.
- `init_done`  out  1  array usable.
- `lkp_vld`  in  1  lookup request.
- `lkp_pc`  in  XLEN  fetch block start address.
- `lkp_rdy`  out  1  lookup accepted this cycle.
- `resp_vld`  out  1  response valid.
- `resp_hit`  out  1  tag match.
- `resp_way`  out  log2(WAYS) (min 1)  hit way.
- `resp_info`  out  ftbInfo_t  stored info; all-zero on miss.
- `resp_fallthru`  out  XLEN  reconstructed fall-through PC.
- `resp_target`  out  XLEN  reconstructed target PC.
- `upd_vld`  in  1  training update.
- `upd_pc`  in  XLEN  fetch block start address.
- `upd_taken`  in  1  resolved direction.
- `upd_info`  in  ftbInfo_t  new entry contents; `counter` field is ignored.

## Operation
- Indexing: `idx = pc[IDX_W:1]`, `IDX_W = log2(SETS)`. Tag: `pc[IDX_W+TAG_W : IDX_W+1]`.
- FSM `INIT`/`RUN`. Reset and `flush` enter `INIT` with walk pointer 0. `INIT` clears valid bits and round-robin pointers of one set per cycle, then moves to `RUN` after set `SETS-1` has been cleared. `flush` during `INIT` restarts at 0.
- `lkp_rdy = init_done & ~upd_vld & ~flush`; updates take priority.
- Lookup: compare the tag against all ways of the set. Multiple hits are impossible by construction. If one is forced, take the lowest way.
- Update hit: overwrite the info fields with `upd_info`. `counter` saturates: +1 if taken (max 3), −1 otherwise (min 0).
- Update miss: pick the victim as the lowest invalid way, else the set's round-robin pointer. The pointer advances (mod `WAYS`) only on eviction of a valid entry. Write tag, vld=1, `upd_info`, and counter = 2 if taken, else 1.
- Updates are ignored while `init_done=0`.
- Fall-through: `{pc[XLEN-1:FALLTHRU_W+1] + carry, fallthruAddr, 1'b0}`.
- Target upper bits: `pc[XLEN-1:TARGET_W+1]`; FIT: unchanged, OVF: +1, UDF: −1, any other encoding: treated as FIT. Arithmetic wraps modulo the upper-field width, then concatenate `targetAddr, 1'b0`.
- PCs are computed from the registered lookup PC.

## Timing
- Reset values: `init_done=0`, `resp_vld=0`, `resp_hit=0`, `resp_way=0`, `resp_info=0`, `resp_fallthru=0`, `resp_target=0`; FSM in `INIT`, walk pointer 0.
- `init_done` rises exactly `SETS` cycles after reset deassertion or after the last `flush`.
- Lookup latency is 1 cycle: the array is read in the accepting cycle, and the response is registered at the next edge. `resp_vld` is a one-cycle pulse per accepted lookup.
- An update written at edge T is visible to a lookup accepted in cycle T+1.
- `flush` squashes the response due the following cycle (`resp_vld=0`).
- Reset asserted mid-walk or mid-response clears all state asynchronously.

## Structure
- Place `ftbInfo_t`, `tarStat_t`, and `BranchType` in the shared frontend define header; do not duplicate them locally.
- Address reconstruction goes in one parametrised combinational sub-module, `ftb_addr_calc`, with parameters `XLEN`, `TARGET_W`, `FALLTHRU_W`.
- Storage is flop arrays: per-set valid/tag/info per way, plus a per-set round-robin pointer.

## Test plan
- Reset, then hold `lkp_vld`: `init_done` rises at cycle 256 (default), `lkp_rdy` is 0 before it, and the first lookup of PC 0x8000_0000 returns `resp_hit=0` with `resp_info=0`.
- Update PC 0x1000, taken, target offset 0x40, FIT. Next-cycle lookup gives hit, counter 2, `resp_target=0x80`, and `resp_fallthru` per carry/offset.
- Apply 3 taken updates to the same PC: counter reads 3 and stays 3. Then 4 not-taken updates: counter reads 0.
- Allocate WAYS+1 distinct tags into set 0 (PCs differing only above bit `IDX_W`): the first four fill ways 0–3, the fifth evicts way 0, and a lookup of the first PC misses.
- With TARGET_W=20, pc=0x0020_0000: UDF gives upper−1 and OVF gives upper+1. At pc=0xFFFF_FFFF_FFE0_0000, OVF wraps the upper field to 0.
- `flush` one cycle after a lookup squashes `resp_vld`. All entries miss after `init_done` re-rises 256 cycles later. An `upd_vld` and a `lkp_vld` in the same cycle give `lkp_rdy=0`.
